perceptron_ctrl: RTL and testbench
==================================

PERCEPTRON_CTRL -- requirements
Module: perceptron_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, cycles the operands are held on the classifier before its output is sampled; legal range 1..15.
REQ-002 clk  input  1  single block clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 flush  input  1  synchronous abort of any in-flight operation.
REQ-005 a_valid, a_ready, b_valid, b_ready  input/output/input/output  1 each  request handshake for requester A (id 0) and requester B (id 1).
REQ-006 a_edges, b_edges  input  3  edge-count feature per requester.
REQ-007 a_curves, b_curves  input  4  curve-count feature per requester.
REQ-008 cls_edges  output  3  operand to the shared combinational classifier.
REQ-009 cls_curves  output  4  operand to the shared combinational classifier.
REQ-010 cls_out  input  4  classifier result; 0..9 are valid classes.
REQ-011 res_valid, res_ready  output/input  1 each  result handshake.
REQ-012 res_class  output  4  captured class.
REQ-013 res_reject  output  1  high when the captured cls_out exceeds 9.
REQ-014 res_id  output  1  id of the requester that owns the result.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done_count  output  8  completed results, saturating.

Function
REQ-017 FSM states are IDLE, SETTLE and RESP; there are no others.
REQ-018 IDLE: when either valid is high, the arbiter grants exactly one requester and asserts only that requester's ready combinationally in the same cycle.
REQ-019 Arbitration is round-robin: with both valid, the grant goes to the requester not granted last; after reset, A wins the first tie.
REQ-020 On the accept edge (valid&ready), the features are latched into the operand registers, the id is latched, the settle counter loads SETTLE_CYCLES-1, and the FSM enters SETTLE.
REQ-021 cls_edges/cls_curves always drive the operand registers; in IDLE they hold the last operands (0 after reset).
REQ-022 SETTLE: the counter decrements each cycle; on the edge where it equals 0, the block captures res_class=cls_out, res_reject=(cls_out>9) and res_id, and enters RESP.
REQ-023 Latency: res_valid rises exactly SETTLE_CYCLES edges after the accept edge.
REQ-024 RESP: res_valid is high and res_class/res_reject/res_id are stable until the edge where res_ready is high, then the FSM returns to IDLE.
REQ-025 Both readies are low in SETTLE and RESP; no new request is accepted in the RESP-exit cycle, so there is at least one IDLE cycle between results.
REQ-026 done_count increments on each res_valid&res_ready edge and saturates at 255.
REQ-027 flush high forces IDLE on the next edge from any state, drops any pending result (res_valid low), leaves done_count and the round-robin pointer unchanged, and takes priority over every other transition.
REQ-028 flush high in IDLE blocks the grant: both readies are low.
REQ-029 A requester whose valid drops before grant is simply not served; the block makes no assumption about valid stability.

Reset
REQ-030 While rst_n is low, state=IDLE, all outputs are 0 (res_valid, readies, busy, res_class, res_reject, res_id, cls_edges, cls_curves, done_count), and the round-robin pointer favours A.
REQ-031 Reset mid-operation discards the operation without emitting a result.

Structure
REQ-032 Package perceptron_pkg holds the FSM state enum, NUM_CLASSES=10, EDGE_W=3, CURVE_W=4 and CLASS_W=4.
REQ-033 The two-way round-robin grant logic is sub-module rr_arbiter2 (inputs req[1:0] and advance; output gnt[1:0]).

Verification
REQ-034 SETTLE_CYCLES=2, A sends edges=4, curves=2, model cls_out=7 -> res_valid 2 edges after accept, res_class=7, res_id=0, res_reject=0, done_count=1.
REQ-035 A and B valid together for 4 results with res_ready held high -> grant order A, B, A, B; no two-cycle ready overlap.
REQ-036 Model cls_out=12 -> res_reject=1, res_class=12.
REQ-037 res_ready held low for 10 cycles in RESP -> outputs stable, readies low, busy high; on release, done_count increments once.
REQ-038 flush asserted during SETTLE -> IDLE next edge, no res_valid pulse, done_count unchanged; rst_n pulsed low in RESP -> all outputs 0 immediately.
REQ-039 256 completions -> done_count holds at 255.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared types and widths for the perceptron request controller.
// The reject rule for classifier results also lives here.
package perceptron_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int EDGE_W      = 3;
    localparam int CURVE_W     = 4;
    localparam int CLASS_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Any class code above the last valid class is a reject.
    function automatic logic is_reject(input logic [CLASS_W-1:0] cls);
        return (cls > CLASS_W'(NUM_CLASSES - 1));
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// A tie goes to the requester not granted last, and requester 0 wins the first tie after reset.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // Grant decode and pointer update
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (advance) begin
            last_d = gnt[1];
        end else begin
            last_d = last_q;
        end
    end

    // Last-granted pointer, reset so that A wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/perceptron_ctrl.sv
// Arbitrates two feature requesters onto a shared combinational classifier.
// It holds the operands for a settle window, then returns the class with a ready/valid handshake.
module perceptron_ctrl
    import perceptron_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [EDGE_W-1:0]  a_edges,
    input  logic [EDGE_W-1:0]  b_edges,
    input  logic [CURVE_W-1:0] a_curves,
    input  logic [CURVE_W-1:0] b_curves,
    output logic [EDGE_W-1:0]  cls_edges,
    output logic [CURVE_W-1:0] cls_curves,
    input  logic [CLASS_W-1:0] cls_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CLASS_W-1:0] res_class,
    output logic               res_reject,
    output logic               res_id,
    output logic               busy,
    output logic [7:0]         done_count
);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [EDGE_W-1:0]    edges_q, edges_d;
    logic [CURVE_W-1:0]   curves_q, curves_d;
    logic                 id_q, id_d;
    logic                 res_valid_q, res_valid_d;
    logic [CLASS_W-1:0]   res_class_q, res_class_d;
    logic                 res_reject_q, res_reject_d;
    logic                 res_id_q, res_id_d;
    logic [7:0]           done_q, done_d;
    logic                 grant_en_s;
    logic [1:0]           gnt_s;
    logic                 accept_s;

    // Grants are offered only in IDLE, outside reset and flush
    assign grant_en_s = rst_n && !flush && (state_q == ST_IDLE);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({b_valid, a_valid} & {2{grant_en_s}}),
        .advance (accept_s),
        .gnt     (gnt_s)
    );

    assign a_ready    = gnt_s[0];
    assign b_ready    = gnt_s[1];
    assign accept_s   = (a_valid & gnt_s[0]) | (b_valid & gnt_s[1]);
    assign cls_edges  = edges_q;
    assign cls_curves = curves_q;
    assign res_valid  = res_valid_q;
    assign res_class  = res_class_q;
    assign res_reject = res_reject_q;
    assign res_id     = res_id_q;
    assign busy       = (state_q != ST_IDLE);
    assign done_count = done_q;

    // Next-state, operand capture and result capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        edges_d      = edges_q;
        curves_d     = curves_q;
        id_d         = id_q;
        res_valid_d  = res_valid_q;
        res_class_d  = res_class_q;
        res_reject_d = res_reject_q;
        res_id_d     = res_id_q;
        done_d       = done_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    edges_d  = gnt_s[1] ? b_edges  : a_edges;
                    curves_d = gnt_s[1] ? b_curves : a_curves;
                    id_d     = gnt_s[1];
                    cnt_d    = 4'(SETTLE_CYCLES - 1);
                    state_d  = ST_SETTLE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    res_class_d  = cls_out;
                    res_reject_d = is_reject(cls_out);
                    res_id_d     = id_q;
                    res_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d        = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    done_d      = (done_q == 8'hFF) ? done_q : done_q + 8'd1;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
            end
        endcase
        // Flush wins over everything but keeps the completion count
        if (flush) begin
            state_d     = ST_IDLE;
            res_valid_d = 1'b0;
            done_d      = done_q;
        end else begin
            state_d     = state_d;
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            edges_q      <= '0;
            curves_q     <= '0;
            id_q         <= 1'b0;
            res_valid_q  <= 1'b0;
            res_class_q  <= '0;
            res_reject_q <= 1'b0;
            res_id_q     <= 1'b0;
            done_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            edges_q      <= edges_d;
            curves_q     <= curves_d;
            id_q         <= id_d;
            res_valid_q  <= res_valid_d;
            res_class_q  <= res_class_d;
            res_reject_q <= res_reject_d;
            res_id_q     <= res_id_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_perceptron_ctrl.sv
// Directed bench for perceptron_ctrl with SETTLE_CYCLES=2.
// The classifier is a bench-driven value, and all expectations are hand-computed.
module tb_perceptron_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic       a_ready, b_ready;
    logic [2:0] a_edges = 3'd0, b_edges = 3'd0;
    logic [3:0] a_curves = 4'd0, b_curves = 4'd0;
    logic [2:0] cls_edges;
    logic [3:0] cls_curves;
    logic [3:0] cls_val = 4'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_class;
    logic       res_reject, res_id, busy;
    logic [7:0] done_count;

    int npass = 0, ntotal = 0, nfail = 0;

    perceptron_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .a_valid(a_valid), .a_ready(a_ready), .b_valid(b_valid), .b_ready(b_ready),
        .a_edges(a_edges), .b_edges(b_edges), .a_curves(a_curves), .b_curves(b_curves),
        .cls_edges(cls_edges), .cls_curves(cls_curves), .cls_out(cls_val),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_reject(res_reject), .res_id(res_id), .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_readies"}, 32'({b_ready, a_ready}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, 32'({res_class, res_reject, res_id}), 32'd0);
        chk({tag, "_operands"}, 32'({cls_edges, cls_curves}), 32'd0);
        chk({tag, "_done"}, 32'(done_count), 32'd0);
    endtask

    initial begin
        int nseen;
        int cyc;

        // Reset with A requesting: everything must stay at zero
        a_valid = 1'b1;
        #12;
        chk_all_zero("reset");
        a_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single A request, class 7
        a_valid = 1'b1; a_edges = 3'd4; a_curves = 4'd2; cls_val = 4'd7;
        #1;
        chk("a_only_grant", 32'({b_ready, a_ready}), 32'd1);
        tick();
        a_valid = 1'b0;
        chk("settle_busy", 32'(busy), 32'd1);
        chk("settle_readies", 32'({b_ready, a_ready}), 32'd0);
        chk("op_edges", 32'(cls_edges), 32'd4);
        chk("op_curves", 32'(cls_curves), 32'd2);
        chk("lat_edge1", 32'(res_valid), 32'd0);
        tick();
        chk("lat_edge1b", 32'(res_valid), 32'd0);
        tick();
        chk("lat_edge2", 32'(res_valid), 32'd1);
        chk("a_class", 32'(res_class), 32'd7);
        chk("a_id", 32'(res_id), 32'd0);
        chk("a_reject", 32'(res_reject), 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("a_done", 32'(done_count), 32'd1);
        chk("a_resp_exit", 32'({busy, res_valid}), 32'd0);

        // B request with out-of-range class 12, then long backpressure
        b_valid = 1'b1; b_edges = 3'd1; b_curves = 4'd9; cls_val = 4'd12;
        #1;
        chk("b_only_grant", 32'({b_ready, a_ready}), 32'd2);
        tick();
        b_valid = 1'b0;
        tick();
        tick();
        chk("rej_valid", 32'(res_valid), 32'd1);
        chk("rej_class", 32'(res_class), 32'd12);
        chk("rej_flag", 32'(res_reject), 32'd1);
        chk("rej_id", 32'(res_id), 32'd1);
        cls_val = 4'd5;
        a_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_result", 32'({res_class, res_reject, res_id}), 32'({4'd12, 1'b1, 1'b1}));
            chk("hold_readies", 32'({b_ready, a_ready}), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        a_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        chk("hold_release_done", 32'(done_count), 32'd2);
        chk("hold_release_valid", 32'(res_valid), 32'd0);
        tick();
        chk("hold_done_once", 32'(done_count), 32'd2);

        // Both requesting: grants alternate A, B, A, B
        a_valid = 1'b1; b_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cls_val = 4'(k + 1);
            #1;
            chk("rr_grant", 32'({b_ready, a_ready}), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            chk("rr_settle_readies", 32'({b_ready, a_ready}), 32'd0);
            tick();
            tick();
            chk("rr_valid", 32'(res_valid), 32'd1);
            chk("rr_id", 32'(res_id), 32'(k % 2));
            chk("rr_class", 32'(res_class), 32'(k + 1));
            chk("rr_exit_readies", 32'({b_ready, a_ready}), 32'd0);
            tick();
            chk("rr_after_exit", 32'(res_valid), 32'd0);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("rr_done", 32'(done_count), 32'd6);

        // Flush during SETTLE drops the operation
        res_ready = 1'b0;
        a_valid = 1'b1;
        #1;
        chk("fl_grant", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_idle", 32'(busy), 32'd0);
        chk("fl_no_valid", 32'(res_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fl_no_pulse", 32'(res_valid), 32'd0);
        end
        chk("fl_done", 32'(done_count), 32'd6);

        // Flush in IDLE blocks the grant; pointer still remembers A
        flush = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("fl_idle_readies", 32'({b_ready, a_ready}), 32'd0);
        tick();
        chk("fl_idle_no_accept", 32'(busy), 32'd0);
        flush = 1'b0;
        b_edges = 3'd5; b_curves = 4'd11; cls_val = 4'd9;
        #1;
        chk("fl_ptr_kept", 32'({b_ready, a_ready}), 32'd2);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("rst_pre_ops", 32'({cls_edges, cls_curves}), 32'({3'd5, 4'd11}));
        tick();
        tick();
        chk("rst_pre_valid", 32'(res_valid), 32'd1);
        chk("rst_pre_class", 32'({res_class, res_id}), 32'({4'd9, 1'b1}));

        // Asynchronous reset in RESP clears everything at once
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;

        // 256 back-to-back completions saturate the counter
        a_valid = 1'b1; a_edges = 3'd3; a_curves = 4'd3; cls_val = 4'd1; res_ready = 1'b1;
        nseen = 0;
        cyc = 0;
        while (nseen < 256 && cyc < 2000) begin
            tick();
            cyc++;
            if (res_valid) begin
                nseen++;
                tick();
                cyc++;
                if (nseen == 254) chk("sat_254", 32'(done_count), 32'd254);
                if (nseen == 255) chk("sat_255", 32'(done_count), 32'd255);
                if (nseen == 256) chk("sat_hold", 32'(done_count), 32'd255);
            end
        end
        chk("sat_completions", 32'(nseen), 32'd256);
        a_valid = 1'b0;
        res_ready = 1'b0;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
